bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Round-robin arbiter granting one shared bus to one of N_REQ processing elements (PEs); 4 in the PE cluster.
- Grant is a registered one-hot vector.
- The owner keeps the bus while it holds its request, subject to an anti-starvation hold limit.
- Sits between the PE request lines and the shared-bus mux select.

Parameters:
- N_REQ, 4, number of requesters; width of req/grant; legal range 2..16.
- MAX_HOLD, 16, maximum consecutive owned cycles before forced hand-over when another requester is pending; 0 means unlimited.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- req  input  N_REQ  request per PE; bit i = PE i wants the bus; level-sensitive.
- grant  output  N_REQ  registered one-hot grant; all-zero = bus idle.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset (sampled at posedge):
  - grant <= 0.
  - Last-granted pointer <= N_REQ-1, so the first search starts at index 0.
  - Hold counter <= 0.
  - Applies mid-operation too: grant drops to 0 at that edge regardless of req.
- Latency: grant updates only on posedge, one cycle after req is sampled. No combinational path from req to grant.
- Invariant: grant is always zero or one-hot (at most one bit set).
- Per-edge decision when not in reset, with owner = index of current grant bit:
  - No owner and req==0: grant stays 0.
  - No owner and req!=0: grant the first set req bit searching circularly from (pointer+1) mod N_REQ.
  - Owner exists and req[owner]==1 and (MAX_HOLD==0 or hold count < MAX_HOLD or no other req bit set): keep grant; increment hold count, saturating.
  - Owner exists and req[owner]==1, hold count reached MAX_HOLD, and another req bit set: hand over to the next set bit circularly after owner; hold count <= 0.
  - Owner exists and req[owner]==0: re-arbitrate from owner+1 in the same edge (no idle bubble). If req==0, grant <= 0.
- Pointer <= index of each newly issued grant. Pointer is unchanged when grant goes to 0.
- Hold counter resets to 0 on every new grant. Its width is clog2(MAX_HOLD+1), minimum 1 bit.
- Requests not asserted are never granted. A grant is not withdrawn while its req is high, except by reset or hold-limit hand-over.
- Simultaneous owner release and new requests: the new requests are eligible at the same edge under round-robin order.
- No X propagation: req bits sampled as X are not required to be handled; the bench drives known values only.

Decomposition:
- Shared package bus_arb_pkg:
  - default N_REQ/MAX_HOLD constants.
  - clog2 helper function.
- Sub-module rr_pick (combinational):
  - inputs: req vector, start index.
  - outputs: one-hot pick and its index, via a circular priority search (double-width mask or rotate/priority-encode/rotate-back).
- Top level holds the grant, pointer and hold-counter registers and the decision logic above.

Test Plan:
- Reset then single request: reset 1 cycle, req=0001 -> grant 0000 during reset, 0001 at next edge; req=0000 -> grant 0000 next edge.
- Round-robin start: pointer at 0 after granting PE0, idle, then req=1010 -> grant 0010 (PE1 precedes PE3); owner drops, req=1000 -> grant 1000 next edge.
- Seamless hand-off: owner PE1 (grant 0010), req changes 0010->0100 -> grant 0100 at the next edge with no 0000 cycle; then req=0010 -> grant 0010.
- All requesting with hold limit (MAX_HOLD=16): owner PE1, req=1111 held -> grant 0010 for 16 further cycles, then 0100, then 1000 after 16 more, then 0001; never two bits set.
- Persistent single requester: req=0001 held 50 cycles -> grant 0001 throughout (no contention, no forced release); req=0000 -> grant 0000 next edge.
- Reset mid-operation: grant=0100 with req=1111, assert reset one edge -> grant 0000; release with req=1111 -> grant 0001 (pointer restored to start at 0).

Source files
------------

// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared defaults and helpers for the bus arbiter
package bus_arb_pkg;

    localparam int N_REQ_DEF    = 4;
    localparam int MAX_HOLD_DEF = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - circular priority search: first set req bit at or after start
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IW    = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    start,
    output logic [N_REQ-1:0] pick,
    output logic [IW-1:0]    idx,
    output logic             any
);

    always_comb begin
        int j;
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        j    = 0;
        for (int off = 0; off < N_REQ; off++) begin
            j = int'(start) + off;
            if (j >= N_REQ) j = j - N_REQ;
            if (!any && req[j]) begin
                any     = 1'b1;
                idx     = IW'(j);
                pick[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin bus arbiter with registered one-hot grant and hold limit
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant
);

    localparam int IW      = clog2(N_REQ);
    localparam int HW_RAW  = clog2(MAX_HOLD + 1);
    localparam int HW      = (HW_RAW < 1) ? 1 : HW_RAW;
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

    logic [IW-1:0]    ptr;
    logic [HW-1:0]    hold;
    logic [IW-1:0]    owner;
    logic             has_owner;
    logic [IW-1:0]    base;
    logic [IW-1:0]    start;
    logic [N_REQ-1:0] pick;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic             others;
    logic             keep;

    always_comb begin
        owner = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) owner = IW'(i);
        end
    end

    assign has_owner = |grant;
    assign others    = |(req & ~grant);

    // Idle searches after the last grant; an active owner searches after itself.
    assign base  = has_owner ? owner : ptr;
    assign start = (base == LAST_IDX) ? '0 : base + 1'b1;

    assign keep = has_owner && req[owner] &&
                  ((MAX_HOLD == 0) || (hold < HOLD_LIM) || !others);

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req   (req),
        .start (start),
        .pick  (pick),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            grant <= '0;
            ptr   <= LAST_IDX;
            hold  <= '0;
        end else if (keep) begin
            if (hold != {HW{1'b1}}) hold <= hold + 1'b1;
        end else if (pick_any) begin
            grant <= pick;
            ptr   <= pick_idx;
            hold  <= '0;
        end else begin
            grant <= '0;
            hold  <= '0;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - randomized and directed checks of bus_arbiter against a behavioural model
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int MH = 16;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req   = '0;
    logic [N-1:0] grant;

    int total = 0;
    int bad   = 0;

    int m_owner = -1;
    int m_ptr   = N - 1;
    int m_hold  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    bus_arbiter #(
        .N_REQ    (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .grant (grant)
    );

    function automatic int next_after(input int b, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(b + k) % N]) return (b + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] owner_vec(input int o);
        logic [N-1:0] v;
        v = '0;
        if (o >= 0) v[o] = 1'b1;
        return v;
    endfunction

    // Reference: owner index, last-granted index and owned-cycle count.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_owner = -1;
                m_ptr   = N - 1;
                m_hold  = 0;
            end else if (m_owner < 0) begin
                m_owner = next_after(m_ptr, req);
                m_hold  = 0;
                if (m_owner >= 0) m_ptr = m_owner;
            end else if (req[m_owner] &&
                         (MH == 0 || m_hold < MH || (req & ~owner_vec(m_owner)) == '0)) begin
                if (m_hold < MH) m_hold = m_hold + 1;
            end else begin
                m_owner = next_after(m_owner, req);
                m_hold  = 0;
                if (m_owner >= 0) m_ptr = m_owner;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                total++;
                if (grant !== owner_vec(m_owner)) begin
                    bad++;
                    $display("FAIL model_cmp t=%0t req=%b grant=%b expected=%b",
                             $time, req, grant, owner_vec(m_owner));
                end
                total++;
                if ($countones(grant) > 1) begin
                    bad++;
                    $display("FAIL onehot t=%0t grant=%b expected at most one bit", $time, grant);
                end
            end
        end
    end

    task automatic step(input logic rst, input logic [N-1:0] r);
        reset = rst;
        req   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [N-1:0] e);
        total++;
        if (grant !== e) begin
            bad++;
            $display("FAIL %s t=%0t grant=%b expected=%b", nm, $time, grant, e);
        end
    endtask

    initial begin
        logic [N-1:0] r;
        int len;

        step(1'b1, 4'b0001); chk("reset", 4'b0000);
        chk_en = 1'b1;
        step(1'b0, 4'b0001); chk("first_grant", 4'b0001);
        step(1'b0, 4'b0000); chk("release_idle", 4'b0000);

        step(1'b0, 4'b1010); chk("rr_start", 4'b0010);
        step(1'b0, 4'b1000); chk("rr_next", 4'b1000);

        step(1'b0, 4'b0010); chk("handoff_pe1", 4'b0010);
        step(1'b0, 4'b0100); chk("handoff_seamless", 4'b0100);
        step(1'b0, 4'b0010); chk("handoff_back", 4'b0010);

        for (int i = 0; i < MH; i++) begin
            step(1'b0, 4'b1111); chk("hold_pe1", 4'b0010);
        end
        step(1'b0, 4'b1111); chk("limit_to_pe2", 4'b0100);
        for (int i = 0; i < MH; i++) begin
            step(1'b0, 4'b1111); chk("hold_pe2", 4'b0100);
        end
        step(1'b0, 4'b1111); chk("limit_to_pe3", 4'b1000);
        for (int i = 0; i < MH; i++) begin
            step(1'b0, 4'b1111); chk("hold_pe3", 4'b1000);
        end
        step(1'b0, 4'b1111); chk("limit_to_pe0", 4'b0001);

        for (int i = 0; i < 50; i++) begin
            step(1'b0, 4'b0001); chk("single_persist", 4'b0001);
        end
        step(1'b0, 4'b0000); chk("single_release", 4'b0000);

        step(1'b0, 4'b0100); chk("mid_setup", 4'b0100);
        step(1'b0, 4'b1111); chk("mid_keep", 4'b0100);
        step(1'b1, 4'b1111); chk("mid_reset", 4'b0000);
        step(1'b0, 4'b1111); chk("after_reset", 4'b0001);

        for (int blk = 0; blk < 150; blk++) begin
            r   = N'($urandom);
            len = $urandom_range(1, 40);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 7) == 0) r = N'($urandom);
                step($urandom_range(0, 149) == 0, r);
            end
        end
        step(1'b0, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
